// File: rtl/tt_pin_bridge_pkg.sv
// Shared definitions for the TinyTapeout pin bridge: beat-count helper,
// default geometry and the output serialiser state encoding.
package tt_pin_bridge_pkg;

    // Integer ceiling division, used to size beat counts from pin widths.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Default geometry: a 12-bit core behind 6 input and 8 output data pins.
    localparam int DEF_DATA_W    = 12;
    localparam int DEF_IN_PINS   = 6;
    localparam int DEF_OUT_PINS  = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_IN_BEATS  = ceil_div(DEF_DATA_W, DEF_IN_PINS);
    localparam int DEF_OUT_BEATS = ceil_div(DEF_DATA_W, DEF_OUT_PINS);

    // Output serialiser states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } out_state_t;

endpackage

// File: rtl/tt_pin_bridge_fifo.sv
// Input word FIFO for the pin bridge. The head word is held in a register so
// it stays stable (and keeps its last value) while the FIFO is empty. A push
// into a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is reported on 'drop'.
module tt_pin_bridge_fifo
    import tt_pin_bridge_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       empty,
    output logic                       full,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_nx;
    logic              pop_ok;
    logic              push_ok;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign drop      = push && !push_ok;
    assign rd_ptr_nx = rd_ptr + PW'(1);

    // Storage array: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nx;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // The next head is either the word just pushed into an empty (or
            // emptying) FIFO, or the entry behind the one being popped.
            if (empty && push_ok) begin
                head <= push_data;
            end else if (pop_ok && count == (PW+1)'(1) && push_ok) begin
                head <= push_data;
            end else if (pop_ok && count > (PW+1)'(1)) begin
                head <= mem[rd_ptr_nx];
            end
        end
    end

endmodule

// File: rtl/tt_pin_bridge.sv
// TinyTapeout pin bridge: deserialises narrow input beats into core words
// (queued in a FIFO) and serialises core words onto narrow output chunks.
// Optional feature macro: TT_PIN_BRIDGE_LOOPBACK_EN adds a 'loopback' input
// that routes FIFO head words straight into the serialiser.
module tt_pin_bridge
    import tt_pin_bridge_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IN_PINS  = DEF_IN_PINS,
    parameter int OUT_PINS = DEF_OUT_PINS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_PINS-1:0]  pin_in,
    input  logic                pin_strobe,
    input  logic                pin_sync,
`ifdef TT_PIN_BRIDGE_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic [OUT_PINS-1:0] pin_out,
    output logic                pin_out_valid,
    output logic                pin_out_last,
    output logic                pin_ovf,
    output logic [DATA_W-1:0]   in_word,
    output logic                in_valid,
    input  logic                in_ready,
    input  logic [DATA_W-1:0]   out_word,
    input  logic                out_valid,
    output logic                out_ready
);

    localparam int IN_BEATS  = ceil_div(DATA_W, IN_PINS);
    localparam int OUT_BEATS = ceil_div(DATA_W, OUT_PINS);
    localparam int IN_W      = IN_BEATS * IN_PINS;
    localparam int SH_W      = OUT_BEATS * OUT_PINS;
    localparam int BC_W      = $clog2(IN_BEATS + 1);
    localparam int CC_W      = $clog2(OUT_BEATS + 1);

    // ---------------- input deserialiser ----------------
    logic [BC_W-1:0] beat_cnt;
    logic [BC_W-1:0] beat_idx;
    logic [IN_W-1:0] asm_q;
    logic [IN_W-1:0] asm_n;
    logic            beat_last;
    logic            fifo_push;

    // Place the current beat into its slot; sync realigns it to slot 0.
    always_comb begin
        beat_idx = pin_sync ? '0 : beat_cnt;
        asm_n    = asm_q;
        for (int k = 0; k < IN_BEATS; k++) begin
            if (beat_idx == BC_W'(k)) begin
                asm_n[k*IN_PINS +: IN_PINS] = pin_in;
            end
        end
        beat_last = (beat_idx == BC_W'(IN_BEATS - 1));
        fifo_push = pin_strobe && beat_last;
    end

    // Assembly register holding the partial word between beats.
    always_ff @(posedge clk) begin
        if (pin_strobe) begin
            asm_q <= asm_n;
        end
    end

    // Beat counter: advances per strobe, wraps after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pin_strobe) begin
            beat_cnt <= beat_last ? '0 : beat_idx + BC_W'(1);
        end else if (pin_sync) begin
            beat_cnt <= '0;
        end
    end

    // ---------------- input FIFO ----------------
    logic [DATA_W-1:0]      fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_drop;
    logic                   fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;

    tt_pin_bridge_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (asm_n[DATA_W-1:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .count     (fifo_count)
    );

    assign in_word = fifo_head;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_ovf <= 1'b0;
        end else if (fifo_drop) begin
            pin_ovf <= 1'b1;
        end
    end

    // ---------------- serialiser source select ----------------
    out_state_t        st_q;
    logic              rdy_q;
    logic [DATA_W-1:0] src_word;
    logic              src_valid;
    logic              capture;

`ifdef TT_PIN_BRIDGE_LOOPBACK_EN
    logic lb_mode;
    logic lb_q;

    // Loopback selection is only sampled while idle, so a word in flight
    // always finishes from the source it started with.
    assign lb_mode   = (st_q == ST_IDLE) ? loopback : lb_q;
    assign src_word  = lb_mode ? fifo_head : out_word;
    assign src_valid = lb_mode ? !fifo_empty : out_valid;
    assign fifo_pop  = lb_mode ? capture : in_ready;
    assign in_valid  = !fifo_empty && !lb_mode;
    assign out_ready = rdy_q && !lb_mode;

    // Hold the loopback mode for the duration of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q <= 1'b0;
        end else begin
            lb_q <= lb_mode;
        end
    end
`else
    assign src_word  = out_word;
    assign src_valid = out_valid;
    assign fifo_pop  = in_ready;
    assign in_valid  = !fifo_empty;
    assign out_ready = rdy_q;
`endif

    assign capture = src_valid && rdy_q;

    // ---------------- output serialiser ----------------
    logic [SH_W-1:0] sh_q;
    logic [SH_W-1:0] src_pad;
    logic [CC_W-1:0] chunk_q;
    logic [CC_W-1:0] chunk_nx;

    assign src_pad  = SH_W'(src_word);
    assign chunk_nx = chunk_q + CC_W'(1);

    // Output FSM: load on capture, shift one chunk per cycle, return to idle
    // after the last chunk unless a back-to-back word is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= ST_IDLE;
            sh_q          <= '0;
            chunk_q       <= '0;
            pin_out       <= '0;
            pin_out_valid <= 1'b0;
            pin_out_last  <= 1'b0;
            rdy_q         <= 1'b0;
        end else if (capture) begin
            st_q          <= ST_SHIFT;
            pin_out       <= src_pad[OUT_PINS-1:0];
            sh_q          <= src_pad >> OUT_PINS;
            chunk_q       <= '0;
            pin_out_valid <= 1'b1;
            pin_out_last  <= (OUT_BEATS == 1);
            rdy_q         <= (OUT_BEATS == 1);
        end else if (st_q == ST_IDLE || pin_out_last) begin
            st_q          <= ST_IDLE;
            pin_out       <= '0;
            pin_out_valid <= 1'b0;
            pin_out_last  <= 1'b0;
            rdy_q         <= 1'b1;
        end else begin
            pin_out       <= sh_q[OUT_PINS-1:0];
            sh_q          <= sh_q >> OUT_PINS;
            chunk_q       <= chunk_nx;
            pin_out_last  <= (chunk_nx == CC_W'(OUT_BEATS - 1));
            rdy_q         <= (chunk_nx == CC_W'(OUT_BEATS - 1));
        end
    end

endmodule

// File: tb/tb_tt_pin_bridge.sv
// Directed testbench for tt_pin_bridge (default 12-bit / 6-in / 8-out / depth 4).
module tb_tt_pin_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  pin_in;
    logic        pin_strobe;
    logic        pin_sync;
    logic        loopback;
    logic [7:0]  pin_out;
    logic        pin_out_valid;
    logic        pin_out_last;
    logic        pin_ovf;
    logic [11:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_word;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    tt_pin_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pin_in        (pin_in),
        .pin_strobe    (pin_strobe),
        .pin_sync      (pin_sync),
`ifdef TT_PIN_BRIDGE_LOOPBACK_EN
        .loopback      (loopback),
`endif
        .pin_out       (pin_out),
        .pin_out_valid (pin_out_valid),
        .pin_out_last  (pin_out_last),
        .pin_ovf       (pin_ovf),
        .in_word       (in_word),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_word      (out_word),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [5:0] v, input logic sync);
        pin_in     = v;
        pin_sync   = sync;
        pin_strobe = 1'b1;
        tick();
        pin_strobe = 1'b0;
        pin_sync   = 1'b0;
    endtask

    task automatic push_word(input logic [11:0] w);
        logic [11:0] t;
        t = w;
        beat(t[5:0], 1'b0);
        beat(t[11:6], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, pin_ovf, in_word, in_valid, out_ready} !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0",
                     {pin_out, pin_out_valid, pin_out_last, pin_ovf, in_word, in_valid, out_ready});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ready: got %b required 1", out_ready);
        end
    endtask

    task automatic test_deser();
        push_word(12'hABC);
        checks++;
        if (in_valid !== 1'b1 || in_word !== 12'hABC) begin
            fails++;
            $display("FAIL deser_word: got v=%b w=%h required v=1 w=abc", in_valid, in_word);
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        checks++;
        if (in_valid !== 1'b0 || in_word !== 12'hABC) begin
            fails++;
            $display("FAIL deser_pop_hold: got v=%b w=%h required v=0 w=abc", in_valid, in_word);
        end
    endtask

    task automatic test_sync();
        beat(6'h15, 1'b0);
        checks++;
        if (in_valid !== 1'b0) begin
            fails++;
            $display("FAIL sync_partial: got in_valid=%b required 0", in_valid);
        end
        beat(6'h3C, 1'b1);
        beat(6'h2A, 1'b0);
        checks++;
        if (in_valid !== 1'b1 || in_word !== 12'hABC) begin
            fails++;
            $display("FAIL sync_word: got v=%b w=%h required v=1 w=abc", in_valid, in_word);
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        checks++;
        if (in_valid !== 1'b0) begin
            fails++;
            $display("FAIL sync_single: got in_valid=%b required 0", in_valid);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] w [5];
        w[0] = 12'h111; w[1] = 12'h2A2; w[2] = 12'h353; w[3] = 12'h4C4; w[4] = 12'hF05;
        in_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(w[i]);
        checks++;
        if (pin_ovf !== 1'b0 || in_word !== w[0]) begin
            fails++;
            $display("FAIL ovf_fill: got ovf=%b head=%h required ovf=0 head=%h", pin_ovf, in_word, w[0]);
        end
        push_word(w[4]);
        checks++;
        if (pin_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got %b required 1", pin_ovf);
        end
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_valid !== 1'b1 || in_word !== w[i]) begin
                fails++;
                $display("FAIL ovf_pop%0d: got v=%b w=%h required v=1 w=%h", i, in_valid, in_word, w[i]);
            end
            tick();
        end
        in_ready = 1'b0;
        checks++;
        if (in_valid !== 1'b0 || pin_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drained: got v=%b ovf=%b required v=0 ovf=1", in_valid, pin_ovf);
        end

        do_reset();
        for (int i = 0; i < 4; i++) push_word(w[i]);
        beat(w[4][5:0], 1'b0);
        checks++;
        if (in_word !== w[0]) begin
            fails++;
            $display("FAIL ovf2_head: got %h required %h", in_word, w[0]);
        end
        in_ready = 1'b1;
        beat(w[4][11:6], 1'b0);
        in_ready = 1'b0;
        checks++;
        if (pin_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf2_clear: got %b required 0", pin_ovf);
        end
        in_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (in_valid !== 1'b1 || in_word !== w[i]) begin
                fails++;
                $display("FAIL ovf2_pop%0d: got v=%b w=%h required v=1 w=%h", i, in_valid, in_word, w[i]);
            end
            tick();
        end
        in_ready = 1'b0;
        checks++;
        if (in_valid !== 1'b0) begin
            fails++;
            $display("FAIL ovf2_empty: got %b required 0", in_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_word  = 12'hABC;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, out_ready} !== {8'hBC, 3'b100}) begin
            fails++;
            $display("FAIL ser_c0: got %h/%b/%b/%b required bc/1/0/0", pin_out, pin_out_valid, pin_out_last, out_ready);
        end
        tick();
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, out_ready} !== {8'h0A, 3'b111}) begin
            fails++;
            $display("FAIL ser_c1: got %h/%b/%b/%b required 0a/1/1/1", pin_out, pin_out_valid, pin_out_last, out_ready);
        end
        out_word  = 12'h123;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last} !== {8'h23, 2'b10}) begin
            fails++;
            $display("FAIL b2b_c0: got %h/%b/%b required 23/1/0", pin_out, pin_out_valid, pin_out_last);
        end
        tick();
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last} !== {8'h01, 2'b11}) begin
            fails++;
            $display("FAIL b2b_c1: got %h/%b/%b required 01/1/1", pin_out, pin_out_valid, pin_out_last);
        end
        tick();
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, out_ready} !== {8'h00, 3'b001}) begin
            fails++;
            $display("FAIL ser_idle: got %h/%b/%b/%b required 00/0/0/1", pin_out, pin_out_valid, pin_out_last, out_ready);
        end
    endtask

    task automatic test_reset_mid_word();
        beat(6'h07, 1'b0);
        out_word  = 12'h5A5;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        checks++;
        if (pin_out_valid !== 1'b1 || pin_out !== 8'hA5) begin
            fails++;
            $display("FAIL mid_shift: got v=%b d=%h required v=1 d=a5", pin_out_valid, pin_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, pin_ovf, in_word, in_valid, out_ready} !== 24'h0) begin
            fails++;
            $display("FAIL async_reset: got %h required 0",
                     {pin_out, pin_out_valid, pin_out_last, pin_ovf, in_word, in_valid, out_ready});
        end
        tick();
        rst_n = 1'b1;
        tick();
        push_word(12'hABC);
        checks++;
        if (in_valid !== 1'b1 || in_word !== 12'hABC) begin
            fails++;
            $display("FAIL fresh_word: got v=%b w=%h required v=1 w=abc", in_valid, in_word);
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

`ifdef TT_PIN_BRIDGE_LOOPBACK_EN
    task automatic test_loopback();
        loopback = 1'b1;
        push_word(12'hABC);
        checks++;
        if (in_valid !== 1'b0 || out_ready !== 1'b0) begin
            fails++;
            $display("FAIL lb_gate: got in_valid=%b out_ready=%b required 0/0", in_valid, out_ready);
        end
        tick();
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, in_valid} !== {8'hBC, 3'b100}) begin
            fails++;
            $display("FAIL lb_c0: got %h/%b/%b/%b required bc/1/0/0", pin_out, pin_out_valid, pin_out_last, in_valid);
        end
        tick();
        checks++;
        if ({pin_out, pin_out_valid, pin_out_last, in_valid} !== {8'h0A, 3'b110}) begin
            fails++;
            $display("FAIL lb_c1: got %h/%b/%b/%b required 0a/1/1/0", pin_out, pin_out_valid, pin_out_last, in_valid);
        end
        tick();
        loopback = 1'b0;
        checks++;
        if (pin_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL lb_idle: got %b required 0", pin_out_valid);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        pin_in     = '0;
        pin_strobe = 1'b0;
        pin_sync   = 1'b0;
        loopback   = 1'b0;
        in_ready   = 1'b0;
        out_word   = '0;
        out_valid  = 1'b0;
        test_reset();
        test_deser();
        test_sync();
        test_overflow();
        test_back_to_back();
        test_reset_mid_word();
`ifdef TT_PIN_BRIDGE_LOOPBACK_EN
        test_loopback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
